// File: rtl/core_mem_pkg.sv
// Package core_mem_pkg
//   Shared definitions for the core memory responder: MMIO word addresses,
//   the BOOT/RUN state encoding and the read-pipe slot record.
package core_mem_pkg;

    // Width of the data field in a read-pipe slot; the responder's DATA_W
    // parameter defaults to this value.
    localparam int CORE_DATA_W = 16;

    localparam logic [15:0] MMIO_GPIO_ADDR  = 16'hFFFF;
    localparam logic [15:0] MMIO_CYCLE_ADDR = 16'hFFFE;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } mem_state_e;

    // One slot of the read delay line. Write cycles travel down the pipe as
    // is_write=1 so the output register knows to hold its value.
    typedef struct packed {
        logic                   is_write;
        logic [CORE_DATA_W-1:0] data;
    } rd_slot_t;

endpackage

// File: rtl/mem_boot_loader.sv
// Module mem_boot_loader
//   BOOT/RUN state machine. In BOOT, every boot_valid_i word is written to RAM
//   at the boot pointer, which then advances and wraps at the end of the RAM.
//   boot_done_i moves to RUN, which is left only through reset.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   boot_valid_i    boot word present this cycle
//   boot_data_i     boot word
//   boot_done_i     end of boot image
//   state_o         current state (BOOT/RUN)
//   core_hold_o     registered hold; falls one cycle after entering RUN
//   wr_en_o         RAM write request for the boot word
//   wr_addr_o       RAM index for the boot word (boot pointer)
//   wr_data_o       RAM write data
module mem_boot_loader
    import core_mem_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  boot_valid_i,
    input  logic [DATA_W-1:0]     boot_data_i,
    input  logic                  boot_done_i,
    output mem_state_e            state_o,
    output logic                  core_hold_o,
    output logic                  wr_en_o,
    output logic [DEPTH_LOG2-1:0] wr_addr_o,
    output logic [DATA_W-1:0]     wr_data_o
);

    mem_state_e            state_q, state_d;
    logic [DEPTH_LOG2-1:0] boot_ptr_q, boot_ptr_d;
    logic                  core_hold_q;

    always_comb begin
        state_d    = state_q;
        boot_ptr_d = boot_ptr_q;
        wr_en_o    = 1'b0;
        case (state_q)
            BOOT: begin
                // A word arriving together with boot_done is still stored.
                if (boot_valid_i) begin
                    wr_en_o    = 1'b1;
                    boot_ptr_d = boot_ptr_q + 1'b1;  // natural wrap overwrites from 0
                end
                if (boot_done_i) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            boot_ptr_q  <= '0;
            core_hold_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            boot_ptr_q  <= boot_ptr_d;
            // Follows the current state, so the hold lags entry to RUN by a cycle.
            core_hold_q <= (state_q == BOOT);
        end
    end

    assign state_o     = state_q;
    assign core_hold_o = core_hold_q;
    assign wr_addr_o   = boot_ptr_q;
    assign wr_data_o   = boot_data_i;

endmodule

// File: rtl/core_mem_responder.sv
// Module core_mem_responder
//   Memory-side responder for the core's unified memory port. Serves reads and
//   writes against a word-addressed RAM with a fixed READ_LAT read latency,
//   plus two MMIO words (GPIO output at FFFF, free-running cycle counter at
//   FFFE). The core is held while mem_boot_loader fills the RAM.
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   to_mem_addr               request address (word), sampled every RUN cycle
//   core_to_mem_data          write data
//   core_to_mem_write_enable  1 = write, 0 = read
//   from_mem_data             registered read response, holds across writes
//   boot_valid/data/done      streaming boot image port
//   core_hold                 1 = core must stay stalled
//   gpio_out                  MMIO output register
//   rd_cnt, wr_cnt            saturating RUN read/write counts
//                             (only when MEM_PERF_CNT_EN is defined)
// Configuration macro: MEM_PERF_CNT_EN
module core_mem_responder
    import core_mem_pkg::*;
#(
    parameter int DATA_W     = CORE_DATA_W,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] to_mem_addr,
    input  logic [DATA_W-1:0] core_to_mem_data,
    input  logic              core_to_mem_write_enable,
    output logic [DATA_W-1:0] from_mem_data,
    input  logic              boot_valid,
    input  logic [DATA_W-1:0] boot_data,
    input  logic              boot_done,
    output logic              core_hold,
`ifdef MEM_PERF_CNT_EN
    output logic [DATA_W-1:0] gpio_out,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt
`else
    output logic [DATA_W-1:0] gpio_out
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    mem_state_e            state;
    logic                  boot_we;
    logic [DEPTH_LOG2-1:0] boot_waddr;
    logic [DATA_W-1:0]     boot_wdata;

    mem_boot_loader #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_boot (
        .clk          (clk),
        .rst_n        (rst_n),
        .boot_valid_i (boot_valid),
        .boot_data_i  (boot_data),
        .boot_done_i  (boot_done),
        .state_o      (state),
        .core_hold_o  (core_hold),
        .wr_en_o      (boot_we),
        .wr_addr_o    (boot_waddr),
        .wr_data_o    (boot_wdata)
    );

    // ---------------- request decode ----------------
    logic                  run;
    logic                  is_gpio, is_cycle, mmio_sel;
    logic                  rd_req, gpio_we, run_ram_we;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [DATA_W-1:0]     gpio_q, cycle_cnt_q, mmio_rdata;

    always_comb begin
        run        = (state == RUN);
        is_gpio    = (to_mem_addr == ADDR_W'(MMIO_GPIO_ADDR));
        is_cycle   = (to_mem_addr == ADDR_W'(MMIO_CYCLE_ADDR));
        mmio_sel   = is_gpio | is_cycle;
        // Upper address bits deliberately alias onto the RAM.
        ram_idx    = to_mem_addr[DEPTH_LOG2-1:0];
        rd_req     = run & ~core_to_mem_write_enable;
        gpio_we    = run & core_to_mem_write_enable & is_gpio;
        // Writes to the cycle counter fall through both enables and are lost.
        run_ram_we = run & core_to_mem_write_enable & ~mmio_sel;
        mmio_rdata = is_gpio ? gpio_q : cycle_cnt_q;
    end

    // ---------------- RAM ----------------
    logic [DATA_W-1:0]     ram_q [DEPTH];
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic [DATA_W-1:0]     ram_wdata;

    always_comb begin
        ram_we    = boot_we | run_ram_we;
        ram_waddr = boot_we ? boot_waddr : ram_idx;
        ram_wdata = boot_we ? boot_wdata : core_to_mem_data;
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_waddr] <= ram_wdata;
        end
    end

    // ---------------- MMIO registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_q      <= '0;
            cycle_cnt_q <= '0;
        end else begin
            if (run) begin
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            end
            if (gpio_we) begin
                gpio_q <= core_to_mem_data;
            end
        end
    end

    // ---------------- read pipeline ----------------
    // The first stage is the synchronous RAM read (muxed with MMIO); further
    // stages are plain registers. The output register only loads on read slots.
    logic [DATA_W-1:0] from_mem_data_q;

    if (READ_LAT == 1) begin : g_lat_one
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                from_mem_data_q <= '0;
            end else if (rd_req) begin
                from_mem_data_q <= mmio_sel ? mmio_rdata : ram_q[ram_idx];
            end
        end
    end else begin : g_lat_multi
        rd_slot_t pipe_q [READ_LAT-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < READ_LAT-1; i++) begin
                    pipe_q[i] <= '{is_write: 1'b1, data: '0};
                end
                from_mem_data_q <= '0;
            end else begin
                pipe_q[0].is_write <= ~rd_req;
                if (rd_req) begin
                    pipe_q[0].data <= CORE_DATA_W'(mmio_sel ? mmio_rdata : ram_q[ram_idx]);
                end
                for (int i = 1; i < READ_LAT-1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
                if (!pipe_q[READ_LAT-2].is_write) begin
                    from_mem_data_q <= DATA_W'(pipe_q[READ_LAT-2].data);
                end
            end
        end
    end

    assign from_mem_data = from_mem_data_q;
    assign gpio_out      = gpio_q;

`ifdef MEM_PERF_CNT_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (run) begin
            if (!core_to_mem_write_enable && rd_cnt_q != 32'hFFFF_FFFF) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (core_to_mem_write_enable && wr_cnt_q != 32'hFFFF_FFFF) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_core_mem_responder.sv
module tb_core_mem_responder;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int DEPTH_LOG2 = 10;
    localparam int READ_LAT   = 3;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [ADDR_W-1:0] to_mem_addr = '0;
    logic [DATA_W-1:0] core_to_mem_data = '0;
    logic              core_to_mem_write_enable = 1'b0;
    logic [DATA_W-1:0] from_mem_data;
    logic              boot_valid = 1'b0;
    logic [DATA_W-1:0] boot_data = '0;
    logic              boot_done = 1'b0;
    logic              core_hold;
    logic [DATA_W-1:0] gpio_out;

    always #5 clk = ~clk;

    core_mem_responder #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .READ_LAT   (READ_LAT)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .to_mem_addr              (to_mem_addr),
        .core_to_mem_data         (core_to_mem_data),
        .core_to_mem_write_enable (core_to_mem_write_enable),
        .from_mem_data            (from_mem_data),
        .boot_valid               (boot_valid),
        .boot_data                (boot_data),
        .boot_done                (boot_done),
        .core_hold                (core_hold),
        .gpio_out                 (gpio_out)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: memory image, MMIO values, and a table of read
    // results keyed by the edge that sampled the request.
    logic [15:0] mem_m [DEPTH];
    logic [15:0] gpio_m, cnt_m, out_m;
    logic        run_m, hold_m;
    int          ptr_m;
    int          tick_n = 0;
    logic [15:0] rd_at [int];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        boot_valid = 1'b0;
        boot_done  = 1'b0;
        #2;
        run_m  = 1'b0;
        hold_m = 1'b1;
        ptr_m  = 0;
        cnt_m  = '0;
        gpio_m = '0;
        out_m  = '0;
        rd_at.delete();
        check("rst_dout", from_mem_data, 16'h0000);
        check("rst_hold", {15'd0, core_hold}, 16'h0001);
        check("rst_gpio", gpio_out, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, advance the model, take the edge, compare.
    task automatic cycle(input logic [15:0] addr, input logic we, input logic [15:0] wd,
                         input logic bv, input logic [15:0] bd, input logic bdn);
        logic hold_nxt;
        to_mem_addr              = addr;
        core_to_mem_write_enable = we;
        core_to_mem_data         = wd;
        boot_valid               = bv;
        boot_data                = bd;
        boot_done                = bdn;
        hold_nxt = !run_m;
        if (!run_m) begin
            if (bv) begin
                mem_m[ptr_m] = bd;
                ptr_m = (ptr_m + 1) % DEPTH;
            end
            if (bdn) run_m = 1'b1;
        end else begin
            if (!we) begin
                if (addr == 16'hFFFF)      rd_at[tick_n] = gpio_m;
                else if (addr == 16'hFFFE) rd_at[tick_n] = cnt_m;
                else                       rd_at[tick_n] = mem_m[addr[9:0]];
            end else if (addr == 16'hFFFF) begin
                gpio_m = wd;
            end else if (addr != 16'hFFFE) begin
                mem_m[addr[9:0]] = wd;
            end
            cnt_m = cnt_m + 16'd1;
        end
        @(posedge clk);
        #1;
        hold_m = hold_nxt;
        if (rd_at.exists(tick_n - READ_LAT + 1)) out_m = rd_at[tick_n - READ_LAT + 1];
        tick_n++;
        check("dout", from_mem_data, out_m);
        check("hold", {15'd0, core_hold}, {15'd0, hold_m});
        check("gpio", gpio_out, gpio_m);
    endtask

    task automatic boot_word(input logic [15:0] d);
        cycle(16'h0000, 1'b0, 16'h0000, 1'b1, d, 1'b0);
    endtask

    task automatic boot_end(input logic v, input logic [15:0] d);
        cycle(16'h0000, 1'b0, 16'h0000, v, d, 1'b1);
    endtask

    task automatic rd(input logic [15:0] a);
        cycle(a, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cycle(a, 1'b1, d, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a1, a2, ra;
        #1;
        do_reset();

        // Reset part-way through a boot restarts the pointer at 0.
        boot_word(16'h1111);
        boot_word(16'h2222);
        do_reset();

        boot_word(16'hAAAA);
        boot_word(16'hBBBB);
        boot_word(16'hCCCC);
        check("hold_in_boot", {15'd0, core_hold}, 16'h0001);
        boot_end(1'b0, 16'h0000);
        check("hold_at_edge", {15'd0, core_hold}, 16'h0001);
        rd(16'h0000);
        check("hold_released", {15'd0, core_hold}, 16'h0000);

        // Three-cycle read latency; previous response held until then.
        rd(16'h0001);
        wr(16'h0030, 16'h7777);
        check("lat_prior_held", from_mem_data, 16'hAAAA);
        wr(16'h0031, 16'h8888);
        check("lat3_data", from_mem_data, 16'hBBBB);
        wr(16'h0032, 16'h9999);
        wr(16'h0033, 16'h4444);
        rd(16'h0033);
        check("write_slot_hold", from_mem_data, 16'hBBBB);

        // Read directly after a write to the same word.
        wr(16'h0010, 16'h5A5A);
        rd(16'h0010);
        rd(16'h0000);
        rd(16'h0000);
        check("read_after_write", from_mem_data, 16'h5A5A);

        wr(16'hFFFF, 16'h00F0);
        check("gpio_write", gpio_out, 16'h00F0);

        // Cycle counter reads ten cycles apart; a write to it is ignored.
        rd(16'hFFFE);
        rd(16'h0000);
        rd(16'h0000);
        a1 = from_mem_data;
        wr(16'hFFFE, 16'h0000);
        for (int i = 0; i < 6; i++) rd(16'h0000);
        rd(16'hFFFE);
        rd(16'h0000);
        rd(16'h0000);
        a2 = from_mem_data;
        check("cycle_diff", a2 - a1, 16'd10);

        // Randomised traffic over a small, fully written window plus aliases.
        for (int i = 3; i < 16; i++) wr(16'(i), 16'($urandom));
        for (int i = 0; i < 300; i++) begin
            int kind;
            kind = $urandom_range(0, 7);
            if (kind < 6) ra = 16'(($urandom_range(0, 63) << 10) | $urandom_range(0, 15));
            else if (kind == 6) ra = 16'hFFFF;
            else ra = 16'hFFFE;
            if ($urandom_range(0, 1) == 1) wr(ra, 16'($urandom));
            else rd(ra);
        end

        // Boot word and boot_done together at pointer 5.
        do_reset();
        for (int i = 0; i < 5; i++) boot_word(16'(16'h5000 + i));
        boot_end(1'b1, 16'h1234);
        rd(16'h0005);
        rd(16'h0000);
        rd(16'h0000);
        check("boot_done_word", from_mem_data, 16'h1234);
        for (int i = 0; i < 8; i++) rd(16'($urandom_range(0, 15)));

        // Boot image longer than the RAM: pointer wraps and overwrites.
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) boot_word(16'($urandom));
        boot_end(1'b0, 16'h0000);
        for (int i = 0; i < 16; i++) rd(16'(i));
        rd(16'h0000);
        rd(16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
